// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver and transmitter.
// No logic of its own; pure declarations plus a small vote helper.
// Not applicable: nothing here carries traffic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Level of an idle serial line; synchroniser flops reset to this.
    localparam logic LINE_IDLE = 1'b1;

    // 2-of-3 majority of three line samples.
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one clk-wide pulse every BAUD_DIV cycles.
// Latency: tick is decoded directly from the counter, no extra register stage.
// Backpressure: none; the tick never stalls and is never restarted by frames.
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int TICK_W = $clog2(BAUD_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_DIV - 1);

    logic [TICK_W-1:0] cnt;

    // Count 0..BAUD_DIV-1 and wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == TICK_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == TICK_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised single-clock UART receiver with parity/framing/overrun reporting.
// Latency: rx_valid rises 1 clk after the tick that samples the last stop bit.
// Backpressure: one-word holding register; a frame completing while it is full is dropped with an overrun_err pulse.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote over ticks mid-1/mid/mid+1, decision on mid+1.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int BAUD_DIV    = 27
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam int MID  = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int DECIDE = MID + 1;
`else
    localparam int DECIDE = MID;
`endif
    localparam logic [OS_W-1:0] OS_DECIDE    = OS_W'(DECIDE);
    localparam logic [OS_W-1:0] OS_LAST      = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST_DATA = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] BC_LAST_STOP = BC_W'(STOP_BITS - 1);

    logic                 sync_q1;
    logic                 sync_q2;
    logic                 tick;
    logic                 bit_val;
    logic                 sample_now;
    rx_state_t            state;
    logic [OS_W-1:0]      os_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;
    logic                 frm_err_q;

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= LINE_IDLE;
            sync_q2 <= LINE_IDLE;
        end else begin
            sync_q1 <= rx_line;
            sync_q2 <= sync_q1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the line value seen on the two previous ticks for the vote.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= {2{LINE_IDLE}};
        end else if (tick) begin
            hist <= {hist[0], sync_q2};
        end
    end

    assign bit_val = maj3({hist, sync_q2});
`else
    assign bit_val = sync_q2;
`endif

    // Bit phase is fixed at start detection; every later decision is a whole bit apart.
    assign sample_now = tick && (os_cnt == OS_DECIDE);

    // Frame FSM plus output holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    os_cnt <= '0;
                    if (!sync_q2) begin
                        state <= START;
                    end
                end
                START: begin
                    if (sample_now) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            state     <= DATA;
                            bit_cnt   <= '0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample_now) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BC_LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_now) begin
                        par_err_q <= (PARITY_MODE == PAR_ODD) ? ~(^shreg ^ bit_val)
                                                              : (^shreg ^ bit_val);
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (sample_now) begin
                        if (bit_cnt == BC_LAST_STOP) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            if (!rx_valid || rx_ready) begin
                                rx_data    <= shreg;
                                parity_err <= par_err_q;
                                frame_err  <= frm_err_q | ~bit_val;
                                rx_valid   <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            frm_err_q <= frm_err_q | ~bit_val;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
